// File: rtl/id_hazard_stage.sv
// Decode-stage hazard/forwarding unit: a shift-register scoreboard of in-flight
// register writes drives forwarding selects, load-use stalls and immediate extension.
module id_hazard_stage #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int FWD_DEPTH      = 3,
    parameter  int LOAD_STAGE     = 2,
    localparam int SEL_W          = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_dest,
    input  logic                      id_wreg,
    input  logic                      id_is_load,
    input  logic [15:0]               id_imm16,
    input  logic [1:0]                id_imm_mode,
    input  logic                      ex_busy,
    input  logic                      flush,
    output logic                      stall,
    output logic                      issue,
    output logic [SEL_W-1:0]          fwd_a,
    output logic [SEL_W-1:0]          fwd_b,
    output logic [DATA_WIDTH-1:0]     immediate,
    output logic [SEL_W-1:0]          inflight_count
);

    // Index k-1 holds the instruction currently in tracked stage k.
    logic [FWD_DEPTH-1:0]                     r_valid;
    logic [FWD_DEPTH-1:0]                     r_wreg;
    logic [FWD_DEPTH-1:0]                     r_load;
    logic [FWD_DEPTH-1:0][REG_ADDR_WIDTH-1:0] r_dest;
    logic [SEL_W-1:0]                         r_count;

    logic             w_haz_a, w_haz_b;
    logic [SEL_W-1:0] w_fwd_a, w_fwd_b;
    logic [SEL_W-1:0] w_cnt_nxt;

    // Walk oldest to youngest so the youngest matching writer wins.
    always_comb begin
        w_fwd_a = '0;
        w_haz_a = 1'b0;
        w_fwd_b = '0;
        w_haz_b = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (r_valid[k-1] && r_wreg[k-1] && r_dest[k-1] != '0) begin
                if (id_uses_rs && id_rs != '0 && r_dest[k-1] == id_rs) begin
                    w_fwd_a = SEL_W'(k);
                    w_haz_a = r_load[k-1] && (k < LOAD_STAGE);
                end
                if (id_uses_rt && id_rt != '0 && r_dest[k-1] == id_rt) begin
                    w_fwd_b = SEL_W'(k);
                    w_haz_b = r_load[k-1] && (k < LOAD_STAGE);
                end
            end
        end
    end

    assign stall = id_valid & (w_haz_a | w_haz_b | ex_busy);
    assign issue = id_valid & ~stall & ~flush & ~ex_busy;
    assign fwd_a = w_fwd_a;
    assign fwd_b = w_fwd_b;

    always_comb begin
        w_cnt_nxt = '0;
        if (ex_busy) begin
            w_cnt_nxt = r_count;
        end else begin
            if (issue && id_wreg) w_cnt_nxt = w_cnt_nxt + SEL_W'(1);
            for (int k = 1; k < FWD_DEPTH; k++) begin
                if (r_valid[k-1] && r_wreg[k-1]) w_cnt_nxt = w_cnt_nxt + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_wreg  <= '0;
            r_load  <= '0;
            r_dest  <= '0;
            r_count <= '0;
        end else if (!ex_busy) begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wreg[k]  <= r_wreg[k-1];
                r_load[k]  <= r_load[k-1];
                r_dest[k]  <= r_dest[k-1];
            end
            r_valid[0] <= issue;
            r_wreg[0]  <= issue & id_wreg;
            r_load[0]  <= issue & id_is_load;
            r_dest[0]  <= issue ? id_dest : '0;
            r_count    <= w_cnt_nxt;
        end
    end

    assign inflight_count = r_count;

    // Shifting the sign-extended value keeps the upper bits sign-filled for wide data paths.
    logic [DATA_WIDTH-1:0] w_sext, w_zext;
    assign w_sext = {{(DATA_WIDTH-16){id_imm16[15]}}, id_imm16};
    assign w_zext = {{(DATA_WIDTH-16){1'b0}}, id_imm16};

    always_comb begin
        immediate = w_zext;
        case (id_imm_mode)
            2'b00: immediate = w_zext;
            2'b01: immediate = w_sext;
            2'b10: immediate = w_sext << 16;
            2'b11: immediate = w_sext << 2;
            default: immediate = w_zext;
        endcase
    end

endmodule

// File: tb/tb_id_hazard_stage.sv
// Scoreboard bench for id_hazard_stage: a default instance plus a LOAD_STAGE=3 instance.
module tb_id_hazard_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_wreg = 1'b0, id_is_load = 1'b0;
    logic [15:0] id_imm16 = '0;
    logic [1:0]  id_imm_mode = '0;
    logic        ex_busy = 1'b0, flush = 1'b0;

    logic        stall, issue, stall3, issue3;
    logic [1:0]  fwd_a, fwd_b, cnt, fwd_a3, fwd_b3, cnt3;
    logic [31:0] immediate, immediate3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    id_hazard_stage u_dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_wreg(id_wreg),
        .id_is_load(id_is_load), .id_imm16(id_imm16), .id_imm_mode(id_imm_mode),
        .ex_busy(ex_busy), .flush(flush), .stall(stall), .issue(issue), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .immediate(immediate), .inflight_count(cnt)
    );

    id_hazard_stage #(.LOAD_STAGE(3)) u_dut3 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_wreg(id_wreg),
        .id_is_load(id_is_load), .id_imm16(id_imm16), .id_imm_mode(id_imm_mode),
        .ex_busy(ex_busy), .flush(flush), .stall(stall3), .issue(issue3), .fwd_a(fwd_a3),
        .fwd_b(fwd_b3), .immediate(immediate3), .inflight_count(cnt3)
    );

    typedef struct {
        string       sig;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get_act(input string s);
        if (s == "stall")  return {31'b0, stall};
        if (s == "issue")  return {31'b0, issue};
        if (s == "fwd_a")  return {30'b0, fwd_a};
        if (s == "fwd_b")  return {30'b0, fwd_b};
        if (s == "cnt")    return {30'b0, cnt};
        if (s == "imm")    return immediate;
        if (s == "stall3") return {31'b0, stall3};
        if (s == "issue3") return {31'b0, issue3};
        if (s == "fwd_b3") return {30'b0, fwd_b3};
        if (s == "cnt3")   return {30'b0, cnt3};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic ex(input string s, input logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.sig, get_act(e.sig), e.val);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dest,
                         input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dest; id_wreg = wr; id_is_load = ld;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0; ex_busy = 0;
        @(negedge clock);
        reset = 0;
        #1;
        ex("cnt", 0); ex("cnt3", 0); ex("fwd_a", 0); ex("stall", 0);
        sample();
        @(posedge clock);
        #1;
        reset = 1;
    endtask

    logic [15:0] imm_tab[2] = '{16'h8001, 16'h7FFF};
    logic [31:0] imm_exp[2][4] = '{
        '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004},
        '{32'h0000_7FFF, 32'h0000_7FFF, 32'h7FFF_0000, 32'h0001_FFFC}};
    logic [1:0] fwd_seq[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] cnt_seq[4] = '{2'd1, 2'd1, 2'd1, 2'd0};

    initial begin
        do_reset();

        // ALU producer followed by a consumer sliding past every stage
        drive(1, 0, 0, 0, 0, 3, 1, 0);
        ex("issue", 1); ex("stall", 0); ex("fwd_a", 0);
        tick();
        drive(1, 3, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ex("fwd_a", fwd_seq[i]); ex("cnt", cnt_seq[i]); ex("stall", 0); ex("issue", 1);
            tick();
        end

        // $0 never forwards; youngest of two writers wins; both operands resolved independently
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        ex("issue", 1);
        tick();
        drive(1, 0, 0, 1, 0, 5, 1, 0);
        ex("fwd_a", 0); ex("stall", 0); ex("cnt", 1);
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        ex("cnt", 2);
        tick();
        drive(1, 5, 0, 1, 0, 6, 1, 0);
        ex("fwd_a", 1); ex("cnt", 3); ex("stall", 0);
        tick();
        drive(1, 6, 5, 1, 1, 0, 0, 0);
        ex("fwd_a", 1); ex("fwd_b", 2); ex("cnt", 3); ex("stall", 0);
        @(negedge clock);
        sample();
        #2 reset = 0;
        #1;
        ex("cnt", 0); ex("fwd_a", 0); ex("fwd_b", 0); ex("stall", 0); ex("issue", 1);
        sample();
        @(posedge clock);
        #1;
        reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        do_reset();

        // Load-use: one bubble at LOAD_STAGE=2, two at LOAD_STAGE=3
        drive(1, 0, 0, 0, 0, 4, 1, 1);
        ex("issue", 1); ex("issue3", 1);
        tick();
        drive(1, 0, 4, 0, 1, 0, 0, 0);
        ex("stall", 1); ex("issue", 0); ex("stall3", 1); ex("issue3", 0); ex("cnt", 1);
        tick();
        ex("stall", 0); ex("issue", 1); ex("fwd_b", 2);
        ex("stall3", 1); ex("issue3", 0); ex("cnt", 1); ex("cnt3", 1);
        tick();
        ex("stall", 0); ex("issue", 1); ex("fwd_b", 3);
        ex("stall3", 0); ex("issue3", 1); ex("fwd_b3", 3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ex("cnt", 0); ex("cnt3", 0);
        tick();

        // Flush coinciding with a load-use hazard
        drive(1, 0, 0, 0, 0, 9, 1, 1);
        tick();
        drive(1, 9, 0, 1, 0, 0, 0, 0);
        flush = 1;
        ex("stall", 1); ex("issue", 0);
        tick();
        flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Immediate extension modes
        for (int t = 0; t < 2; t++) begin
            for (int m = 0; m < 4; m++) begin
                id_imm16 = imm_tab[t];
                id_imm_mode = 2'(m);
                ex("imm", imm_exp[t][m]);
                tick();
            end
        end

        // Freeze holds the scoreboard; flush squashes without disturbing in-flight entries
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        ex("issue", 1);
        tick();
        ex_busy = 1;
        drive(1, 7, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ex("stall", 1); ex("issue", 0); ex("fwd_a", 1); ex("cnt", 1);
            tick();
        end
        ex_busy = 0;
        flush = 1;
        drive(1, 7, 0, 1, 0, 8, 1, 0);
        ex("fwd_a", 1); ex("stall", 0); ex("issue", 0); ex("cnt", 1);
        tick();
        flush = 0;
        drive(1, 8, 7, 1, 1, 0, 0, 0);
        ex("fwd_a", 0); ex("fwd_b", 2); ex("cnt", 1); ex("stall", 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
